// File: rtl/mem_port_b_reader.sv
// Port-B read DMA: fetches word_count words from base_addr and streams them out through a small FIFO.
// Optional `BYTE_STREAM_EN: each word goes out as four zero-extended byte beats, byte 0 first.
module mem_port_b_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      address_b,
    output logic [31:0]      data_in_b,
    output logic             we_b,
    input  logic [31:0]      data_out_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_FETCH | issuing port-B reads while FIFO credit allows
    // S_DRAIN | all reads issued, emptying the FIFO onto the stream
    // S_DONE  | one-cycle completion pulse

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_base;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_issued;
    logic [LEN_W-1:0] r_popped;
    logic             r_inflight;
    logic [31:0]      r_addr;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_fifo_count;

    logic [LEN_W-1:0] w_count_m1;
    logic [CNT_W-1:0] w_occ;
    logic             w_issue;
    logic [31:0]      w_issue_addr;
    logic             w_push;
    logic             w_pop;
    logic             w_xfer;
    logic             w_word_end;
    logic [31:0]      w_head;
    logic             w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^base_addr[1:0];

    assign w_count_m1   = r_count - LEN_W'(1);
    // The pending read already owns a FIFO slot, so credit counts it.
    assign w_occ        = r_fifo_count + CNT_W'(r_inflight);
    assign w_issue      = (r_state == S_FETCH) && (r_issued != r_count) && (w_occ < DEPTH_C);
    assign w_issue_addr = r_base + {{(30-LEN_W){1'b0}}, r_issued, 2'b00};
    assign w_push       = r_inflight;
    assign w_head       = r_mem[r_rd_ptr];

    assign address_b = w_issue ? w_issue_addr : r_addr;
    assign data_in_b = 32'h0;
    assign we_b      = 1'b0;
    assign busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign out_valid = (r_fifo_count != '0);
    assign w_xfer    = out_valid && out_ready;
    assign w_pop     = w_xfer && w_word_end;
    assign out_last  = out_valid && w_word_end && (r_popped == w_count_m1);

`ifdef BYTE_STREAM_EN
    logic [1:0] r_byte_idx;

    assign w_word_end = (r_byte_idx == 2'd3);
    assign out_data   = out_valid ? {24'h0, w_head[{r_byte_idx, 3'b000} +: 8]} : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_idx <= 2'd0;
        end else if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end
`else
    assign w_word_end = 1'b1;
    assign out_data   = out_valid ? w_head : 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (word_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_issue && (r_issued == w_count_m1)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_popped == w_count_m1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base       <= 32'h0;
            r_count      <= '0;
            r_issued     <= '0;
            r_popped     <= '0;
            r_inflight   <= 1'b0;
            r_addr       <= 32'h0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_base   <= {base_addr[31:2], 2'b00};
                r_count  <= word_count;
                r_issued <= '0;
                r_popped <= '0;
            end
            if (w_issue) begin
                r_addr   <= w_issue_addr;
                r_issued <= r_issued + LEN_W'(1);
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_out_b;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_popped <= r_popped + LEN_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_b_reader.sv
// Bench for mem_port_b_reader: port-B memory model, scoreboard of expected beats, decoupled stream monitor.
module tb_mem_port_b_reader;

    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 16;
`ifdef BYTE_STREAM_EN
    localparam int BPW = 4;
`else
    localparam int BPW = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic [31:0]      address_b;
    logic [31:0]      data_in_b;
    logic             we_b;
    logic [31:0]      data_out_b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_last;

    mem_port_b_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .address_b(address_b),
        .data_in_b(data_in_b), .we_b(we_b), .data_out_b(data_out_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Port-B memory: explicit preloads, otherwise an address-derived pattern.
    logic [31:0] ovr [logic [31:0]];
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction
    always @(posedge clk) data_out_b <= mem_word(address_b);

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;
    beat_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream monitor state, shared with the stimulus process (read only at negedge+1).
    int          ready_mode = 3;
    int          ph = 0;
    int          first_valid_cyc = -1;
    int          last_xfer_cyc = -1;
    int          beats_seen = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;
    bit          addr_chk = 0;
    logic [31:0] abase;
    int          acount;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            ph++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph % 3 == 0);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [31:0] off;
        beat_t b;
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                chk("stall_valid", {31'h0, out_valid}, 32'h1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", {31'h0, out_last}, {31'h0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_beat: got %h, expected no beat (cycle %0d)", out_data, cyc);
                end else begin
                    b = q.pop_front();
                    chk("beat_data", out_data, b.d);
                    chk("beat_last", {31'h0, out_last}, {31'h0, b.l});
                end
                last_xfer_cyc = cyc;
                beats_seen++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (addr_chk && busy) begin
                off = address_b - abase;
                n_cmp++;
                if (off[1:0] != 2'b00 || off >= 32'(4 * acount)) begin
                    n_bad++;
                    $display("FAIL addr_range: got %h, expected within %h + 4*[0,%0d)", address_b, abase, acount);
                end
            end
        end
    end

    task automatic push_expected(input logic [31:0] base, input int count);
        logic [31:0] w;
        logic [31:0] a;
        beat_t b;
        for (int i = 0; i < count; i++) begin
            a = {base[31:2], 2'b00} + 32'(4 * i);
            w = mem_word(a);
            for (int k = 0; k < BPW; k++) begin
                b.d = (BPW == 1) ? w : ((w >> (8 * k)) & 32'hFF);
                b.l = (i == count - 1) && (k == BPW - 1);
                q.push_back(b);
            end
        end
    endtask

    task automatic wait_done(output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: got no done, expected done within 3000 cycles");
        end
    endtask

    task automatic run_block(input logic [31:0] base, input int count, input int mode,
                             input bit extra_start);
        int s;
        int dc;
        logic [31:0] prev_addr;
        ready_mode      = mode;
        first_valid_cyc = -1;
        push_expected(base, count);
        abase     = {base[31:2], 2'b00};
        acount    = count;
        addr_chk  = 1;
        prev_addr = address_b;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = LEN_W'(count);
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; word_count = LEN_W'($urandom);
        @(negedge clk); #1;
        if (count == 0) begin
            chk("zero_addr_hold", address_b, prev_addr);
            chk("zero_done", {31'h0, done}, 32'h1);
            chk("zero_busy", {31'h0, busy}, 32'h0);
            repeat (4) @(negedge clk);
            #1;
            chk("zero_done_once", {31'h0, done}, 32'h0);
            chk("zero_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
        end else begin
            chk("first_addr", address_b, {base[31:2], 2'b00});
            chk("busy_after_start", {31'h0, busy}, 32'h1);
            if (extra_start) begin
                @(posedge clk); #1;
                start = 1'b1; base_addr = 32'hDEAD_0000; word_count = LEN_W'(7);
                @(posedge clk); #1;
                start = 1'b0;
            end
            wait_done(dc);
            chk("done_after_last", 32'(dc), 32'(last_xfer_cyc + 1));
            chk("busy_at_done", {31'h0, busy}, 32'h0);
            chk("sb_empty", 32'(q.size()), 32'h0);
            if (mode == 0) begin
                chk("first_valid_lat", 32'(first_valid_cyc), 32'(s + 3));
                chk("throughput", 32'(dc - s), 32'(3 + count * BPW));
            end
            @(negedge clk); #1;
            chk("done_pulse", {31'h0, done}, 32'h0);
        end
        addr_chk = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_addr"}, address_b, 32'h0);
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_data"}, out_data, 32'h0);
        chk({tag, "_last"}, {31'h0, out_last}, 32'h0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish, expected finish before 60000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        reset = 1'b1; start = 1'b0; base_addr = 32'h0; word_count = '0;
        for (int i = 0; i < 4; i++) ovr[32'h100 + 32'(4 * i)] = 32'(i + 1);
        ovr[32'h400] = 32'hA1B2_C3D4;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("reset");
        chk("we_b_zero", {31'h0, we_b}, 32'h0);
        chk("wdata_zero", data_in_b, 32'h0);

        run_block(32'h100, 4, 0, 0);
        run_block(32'h100, 4, 1, 0);
        run_block(32'h103, 1, 0, 0);
        run_block(32'h200, 0, 0, 0);
        run_block(32'h400, 1, 0, 0);
        run_block(32'hFFFF_FFF8, 4, 2, 0);
        run_block(32'h500, 6, 1, 1);

        // Reset in the middle of a block after two beats.
        ready_mode = 0;
        push_expected(32'h2000, 8);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h2000; word_count = LEN_W'(8);
        @(posedge clk); #1;
        start = 1'b0;
        b0 = beats_seen;
        for (int i = 0; i < 200 && beats_seen < b0 + 2; i++) begin
            @(negedge clk); #1;
        end
        chk("two_beats_before_reset", 32'(beats_seen - b0 >= 2), 32'h1);
        ready_mode = 3;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        @(negedge clk); #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        #1 chk("midreset_quiet", {31'h0, out_valid}, 32'h0);
        run_block(32'h3000, 5, 0, 0);

        for (int r = 0; r < 6; r++) begin
            run_block($urandom, $urandom_range(1, 12), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
